// File: rtl/shift_add_mult_ctrl.sv
// Multi-cycle unsigned 8x8 multiplier: shift-and-add over a single 8-bit
// ripple-carry adder, eight iterations, start/busy/done handshake.

module ripple_carry_adder_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic [8:0] c;

    assign c[0] = ci;
    assign co   = c[8];

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
endmodule

module shift_add_mult_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [7:0] m_q, acc_q, mq_q;
    logic       c_q;
    logic [3:0] cnt;

    logic [7:0] sum;
    logic       co;
    logic [8:0] add_ca;
    logic [7:0] sh_a, sh_q;

    ripple_carry_adder_8 u_add (
        .a  (acc_q),
        .b  (m_q),
        .ci (1'b0),
        .s  (sum),
        .co (co)
    );

    // c_q is always zero entering an iteration (cleared by every shift).
    always_comb begin
        add_ca = mq_q[0] ? {co, sum} : {c_q, acc_q};
        sh_a   = {add_ca[8], add_ca[7:1]};
        sh_q   = {add_ca[0], mq_q[7:1]};
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            c_q     <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    m_q   <= a;
                    mq_q  <= b;
                    acc_q <= '0;
                    c_q   <= 1'b0;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    acc_q <= sh_a;
                    mq_q  <= sh_q;
                    c_q   <= 1'b0;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        product <= {sh_a, sh_q};
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
